multi_lock: RTL
===============

MULTI_LOCK -- requirements
Module: multi_lock

Interface
REQ-001 Parameter NUM_LOCKS, default 4: number of independent lock IDs (1..256).
REQ-002 Parameter ID_W, default 4: width of requester ID (TID/TDEST).
REQ-003 Parameter QUEUE_DEPTH, default 4: waiters per lock (power of two, >=2; used only with LOCK_QUEUE_EN).
REQ-004 ap_clk  in  1  single clock, all logic on rising edge.
REQ-005 ap_rst  in  1  asynchronous, active-high reset.
REQ-006 inStream_TDATA  in  64  request; [7:0] command, [15:8] lock ID, rest ignored.
REQ-007 inStream_TVALID  in  1  request valid.
REQ-008 inStream_TID  in  ID_W  requester ID.
REQ-009 inStream_TREADY  out  1  request accepted when TVALID and TREADY high at a rising edge.
REQ-010 outStream_TDATA  out  8  ack code: 0x01 granted, 0x00 refused.
REQ-011 outStream_TVALID  out  1  ack valid.
REQ-012 outStream_TREADY  in  1  ack consumed when TVALID and TREADY high at a rising edge.
REQ-013 outStream_TDEST  out  ID_W  requester the ack is addressed to.
REQ-014 bad_unlock  out  1  one-cycle pulse on rejected unlock.

Function
REQ-015 Commands: 0x04 LOCK, 0x06 UNLOCK; any other code is consumed and ignored, no ack.
REQ-016 Per lock state: busy flag, owner ID (ID_W bits).
REQ-017 FSM states IDLE, EVAL, ACK; IDLE->EVAL on accepted request; EVAL->ACK if an ack is produced, else EVAL->IDLE; ACK->IDLE on ack handshake.
REQ-018 inStream_TREADY high only in IDLE; one message in flight at a time.
REQ-019 Ack latency: outStream_TVALID high on the second rising edge after request acceptance.
REQ-020 outStream_TVALID, TDATA, TDEST held stable in ACK until handshake; TVALID low the cycle after handshake.
REQ-021 LOCK on free lock: busy set, owner = TID, ack 0x01 to TDEST = TID.
REQ-022 LOCK on busy lock (any requester, including owner): ack 0x00 to TDEST = TID, unless queued (REQ-030).
REQ-023 LOCK with lock ID >= NUM_LOCKS: ack 0x00, no state change.
REQ-024 UNLOCK by owner on busy lock: lock freed (or handed over, REQ-031), no ack unless hand-over.
REQ-025 UNLOCK by non-owner, on free lock, or lock ID >= NUM_LOCKS: no state change, no ack, bad_unlock pulses in EVAL cycle.
REQ-026 Locks independent: operations on one ID never alter another ID's state.

Reset
REQ-027 While ap_rst high, and immediately on its assertion (including mid-transaction or in ACK): state IDLE, all locks free, owners 0, queues empty.
REQ-028 Reset values: inStream_TREADY 0 during reset and 1 from first edge after deassertion; outStream_TVALID 0, outStream_TDATA 0x00, outStream_TDEST 0, bad_unlock 0; an ack pending at reset is dropped.

Configuration
REQ-029 Macro LOCK_QUEUE_EN selects waiter queueing; without it, REQ-022 applies unconditionally and no queue storage exists.
REQ-030 With LOCK_QUEUE_EN: LOCK on busy lock by a non-owner enqueues TID in that lock's FIFO, no immediate ack; ack 0x00 only if that FIFO holds QUEUE_DEPTH entries (full) or requester is owner.
REQ-031 With LOCK_QUEUE_EN: owner UNLOCK with non-empty FIFO pops head, owner = head, lock stays busy, ack 0x01 to TDEST = head with REQ-019 latency; empty FIFO frees lock.
REQ-032 FIFO pointers wrap modulo QUEUE_DEPTH; occupancy counter distinguishes full from empty; strict FIFO order.

Structure
REQ-033 Package multi_lock_pkg holds command codes, ack codes, FSM state enum.
REQ-034 Sub-module lock_waiter_fifo (one instance per lock, generated only with LOCK_QUEUE_EN) implements push/pop/full/empty/head.

Verification
REQ-035 Reset, TVALID 0 -> TREADY 1, outStream_TVALID 0, held over 2 cycles.
REQ-036 LOCK id 0 from TID 0 -> ack 0x01 TDEST 0 on 2nd edge; LOCK id 0 from TID 1 -> ack 0x00 TDEST 1 (no macro); LOCK id 1 from TID 1 -> ack 0x01.
REQ-037 UNLOCK id 0 from TID 5 while owner 0 -> no ack, bad_unlock pulse, owner stays 0; UNLOCK from TID 0 -> no ack, next LOCK from TID 15 -> 0x01 TDEST 15.
REQ-038 Ack held with TREADY low 10 cycles -> TVALID/TDATA/TDEST stable, inStream_TREADY 0; TREADY pulse -> TVALID 0 next cycle.
REQ-039 LOCK_QUEUE_EN, depth 4: owner 0, LOCKs from TIDs 1..4 -> no acks; TID 5 -> 0x00; UNLOCK by 0 -> 0x01 TDEST 1; UNLOCK by 1 -> 0x01 TDEST 2.
REQ-040 Reset asserted during ACK with queued waiters -> TVALID 0 at once; after release LOCK id 0 from TID 3 -> 0x01 TDEST 3.

Source files
------------

// File: rtl/multi_lock_pkg.sv
// multi_lock_pkg -- shared definitions for the multi_lock arbiter.
//   Command codes carried in inStream_TDATA[7:0], ack codes returned on
//   outStream_TDATA, and the request-processing FSM state encoding.
`timescale 1ns/1ps
package multi_lock_pkg;

   localparam logic [7:0] CMD_LOCK   = 8'h04;
   localparam logic [7:0] CMD_UNLOCK = 8'h06;

   localparam logic [7:0] ACK_GRANT  = 8'h01;
   localparam logic [7:0] ACK_REFUSE = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for a request
      ST_EVAL = 2'd1,   // request latched, lock table being updated
      ST_ACK  = 2'd2    // ack presented, waiting for the consumer
   } lockState_t;

endpackage

// File: rtl/lock_waiter_fifo.sv
// lock_waiter_fifo -- FIFO of requester IDs waiting for one lock.
//   Ports:
//     ap_clk, ap_rst   clock, asynchronous active-high reset (empties FIFO)
//     push, pushData   enqueue pushData (ignored when full)
//     pop              dequeue head (ignored when empty)
//     head             oldest waiter, valid while empty is low
//     full, empty      occupancy flags
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
`timescale 1ns/1ps
module lock_waiter_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         ap_clk,
   input  logic         ap_rst,
   input  logic         push,
   input  logic [W-1:0] pushData,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   // One extra bit so a full FIFO is distinguishable from an empty one
   // even though the pointers are equal in both cases.
   logic [PW:0]   count;
   logic          doPush;
   logic          doPop;

   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge ap_clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   assign head  = mem[rdPtr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/multi_lock.sv
// multi_lock -- lock arbiter serving NUM_LOCKS independent locks over a
// request/ack stream pair.
//   Ports:
//     ap_clk, ap_rst      clock, asynchronous active-high reset
//     inStream_*          requests: TDATA[7:0] command, TDATA[15:8] lock ID,
//                         TID requester; TREADY high only when idle
//     outStream_*         acks: TDATA 0x01 granted / 0x00 refused, TDEST
//                         addressed requester
//     bad_unlock          one-cycle pulse when an UNLOCK is rejected
//     dbgState            current FSM state (lockState_t encoding)
//   Build option: define LOCK_QUEUE_EN to queue contending LOCK requests
//   (QUEUE_DEPTH waiters per lock) and hand the lock over on UNLOCK.
`timescale 1ns/1ps
module multi_lock
   import multi_lock_pkg::*;
#(
   parameter int NUM_LOCKS   = 4,
   parameter int ID_W        = 4,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic            ap_clk,
   input  logic            ap_rst,
   input  logic [63:0]     inStream_TDATA,
   input  logic            inStream_TVALID,
   input  logic [ID_W-1:0] inStream_TID,
   output logic            inStream_TREADY,
   output logic [7:0]      outStream_TDATA,
   output logic            outStream_TVALID,
   input  logic            outStream_TREADY,
   output logic [ID_W-1:0] outStream_TDEST,
   output logic            bad_unlock,
   output logic [1:0]      dbgState
);

   // Handshake: a beat transfers on a rising edge where TVALID and TREADY
   // are both high. Once raised, outStream_TVALID/TDATA/TDEST stay put until
   // that transfer; TVALID never waits on TREADY.

   lockState_t state;
   lockState_t nextState;

   logic            rstDone;
   logic            accept;
   logic [7:0]      reqCmd;
   logic [7:0]      reqLock;
   logic [ID_W-1:0] reqTid;

   logic [NUM_LOCKS-1:0] busy;
   logic [ID_W-1:0]      owner [NUM_LOCKS];

   logic [7:0]      ackData;
   logic [ID_W-1:0] ackDest;

   logic            idValid;
   logic            selBusy;
   logic [ID_W-1:0] selOwner;
   logic            lockWr;
   logic            nextBusy;
   logic [ID_W-1:0] nextOwner;
   logic            ackGen;
   logic [7:0]      ackCode;
   logic [ID_W-1:0] ackTo;
   logic            badUnlock;
   logic            unusedBits;

`ifdef LOCK_QUEUE_EN
   logic [NUM_LOCKS-1:0] fifoFull;
   logic [NUM_LOCKS-1:0] fifoEmpty;
   logic [ID_W-1:0]      fifoHead [NUM_LOCKS];
   logic                 selFull;
   logic                 selEmpty;
   logic [ID_W-1:0]      selHead;
   logic                 qPush;
   logic                 qPop;

   for (genvar g = 0; g < NUM_LOCKS; g++) begin : gWait
      lock_waiter_fifo #(
         .DEPTH (QUEUE_DEPTH),
         .W     (ID_W)
      ) uFifo (
         .ap_clk   (ap_clk),
         .ap_rst   (ap_rst),
         .push     (qPush && (reqLock == 8'(g))),
         .pushData (reqTid),
         .pop      (qPop && (reqLock == 8'(g))),
         .head     (fifoHead[g]),
         .full     (fifoFull[g]),
         .empty    (fifoEmpty[g])
      );
   end

   assign unusedBits = ^inStream_TDATA[63:16];
`else
   assign unusedBits = ^{inStream_TDATA[63:16], QUEUE_DEPTH};
`endif

   // Ready is held off until the first edge after reset release.
   assign inStream_TREADY = (state == ST_IDLE) && rstDone;
   assign accept          = inStream_TVALID && inStream_TREADY;

   // Nine-bit compare so NUM_LOCKS = 256 accepts every 8-bit lock ID.
   assign idValid = ({1'b0, reqLock} < 9'(NUM_LOCKS));

   // Select the addressed lock; out-of-range IDs select nothing.
   always_comb begin
      selBusy  = 1'b0;
      selOwner = '0;
`ifdef LOCK_QUEUE_EN
      selFull  = 1'b0;
      selEmpty = 1'b1;
      selHead  = '0;
`endif
      for (int i = 0; i < NUM_LOCKS; i++) begin
         if (reqLock == 8'(i)) begin
            selBusy  = busy[i];
            selOwner = owner[i];
`ifdef LOCK_QUEUE_EN
            selFull  = fifoFull[i];
            selEmpty = fifoEmpty[i];
            selHead  = fifoHead[i];
`endif
         end
      end
   end

   // Next-state and request evaluation.
   always_comb begin
      nextState = state;
      lockWr    = 1'b0;
      nextBusy  = selBusy;
      nextOwner = selOwner;
      ackGen    = 1'b0;
      ackCode   = ACK_REFUSE;
      ackTo     = reqTid;
      badUnlock = 1'b0;
`ifdef LOCK_QUEUE_EN
      qPush     = 1'b0;
      qPop      = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (accept) nextState = ST_EVAL;
         end
         ST_EVAL: begin
            if (reqCmd == CMD_LOCK) begin
               if (!idValid) begin
                  ackGen = 1'b1;
               end else if (!selBusy) begin
                  lockWr    = 1'b1;
                  nextBusy  = 1'b1;
                  nextOwner = reqTid;
                  ackGen    = 1'b1;
                  ackCode   = ACK_GRANT;
               end else begin
`ifdef LOCK_QUEUE_EN
                  // The owner re-locking is refused rather than queued
                  // behind itself.
                  if ((selOwner != reqTid) && !selFull) qPush = 1'b1;
                  else                                  ackGen = 1'b1;
`else
                  ackGen = 1'b1;
`endif
               end
            end else if (reqCmd == CMD_UNLOCK) begin
               if (idValid && selBusy && (selOwner == reqTid)) begin
                  lockWr = 1'b1;
`ifdef LOCK_QUEUE_EN
                  if (!selEmpty) begin
                     // Hand over: lock stays busy, new owner is told.
                     qPop      = 1'b1;
                     nextOwner = selHead;
                     ackGen    = 1'b1;
                     ackCode   = ACK_GRANT;
                     ackTo     = selHead;
                  end else begin
                     nextBusy = 1'b0;
                  end
`else
                  nextBusy = 1'b0;
`endif
               end else begin
                  badUnlock = 1'b1;
               end
            end
            nextState = ackGen ? ST_ACK : ST_IDLE;
         end
         ST_ACK: begin
            if (outStream_TVALID && outStream_TREADY) nextState = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= ST_IDLE;
      else        state <= nextState;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rstDone <= 1'b0;
         reqCmd  <= '0;
         reqLock <= '0;
         reqTid  <= '0;
         busy    <= '0;
         for (int i = 0; i < NUM_LOCKS; i++) owner[i] <= '0;
         ackData <= ACK_REFUSE;
         ackDest <= '0;
      end else begin
         rstDone <= 1'b1;
         if (accept) begin
            reqCmd  <= inStream_TDATA[7:0];
            reqLock <= inStream_TDATA[15:8];
            reqTid  <= inStream_TID;
         end
         if (lockWr) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
               if (reqLock == 8'(i)) begin
                  busy[i]  <= nextBusy;
                  owner[i] <= nextOwner;
               end
            end
         end
         if ((state == ST_EVAL) && ackGen) begin
            ackData <= ackCode;
            ackDest <= ackTo;
         end
      end
   end

   assign outStream_TVALID = (state == ST_ACK);
   assign outStream_TDATA  = ackData;
   assign outStream_TDEST  = ackDest;
   assign bad_unlock       = badUnlock;
   assign dbgState         = state;

endmodule
